// File: rtl/fnn_pkg.sv
// Shared types and defaults for the FNN layer sequencers.
// Holds the sequencer state encoding and the weight/activation pair payload.
package fnn_pkg;

    localparam int unsigned FNN_DATA_W = 16;
    localparam int unsigned FNN_NUM_W  = 30;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic [FNN_DATA_W-1:0] weight;
        logic [FNN_DATA_W-1:0] data;
        logic                  last;
    } pair_t;

    // A pass is in progress while fetching or while returned pairs are still queued.
    function automatic logic seq_active(input seq_state_t s);
        return (s == RUN) || (s == DRAIN);
    endfunction

endpackage

// File: rtl/weight_fetch_sequencer_if.sv
// Bundle of the sequencer's control, activation, weight-memory and MAC-stream signals.
// master is the sequencer side; slave is the surrounding layer logic.
interface weight_fetch_sequencer_if
    import fnn_pkg::*;
#(
    parameter int unsigned dataWidth    = FNN_DATA_W,
    parameter int unsigned addressWidth = $clog2(FNN_NUM_W)
);

    logic                    start;
    logic                    busy;
    logic                    done;

    logic                    in_valid;
    logic [dataWidth-1:0]    in_data;
    logic                    in_ready;

    logic                    mem_ren;
    logic [addressWidth-1:0] mem_radd;
    logic [dataWidth-1:0]    mem_wout;

    logic                    out_valid;
    logic                    out_ready;
    logic [dataWidth-1:0]    out_weight;
    logic [dataWidth-1:0]    out_data;
    logic                    out_last;

    modport master (
        input  start,
        input  in_valid,
        input  in_data,
        input  mem_wout,
        input  out_ready,
        output busy,
        output done,
        output in_ready,
        output mem_ren,
        output mem_radd,
        output out_valid,
        output out_weight,
        output out_data,
        output out_last
    );

    modport slave (
        output start,
        output in_valid,
        output in_data,
        output mem_wout,
        output out_ready,
        input  busy,
        input  done,
        input  in_ready,
        input  mem_ren,
        input  mem_radd,
        input  out_valid,
        input  out_weight,
        input  out_data,
        input  out_last
    );

endinterface

// File: rtl/pair_skid_fifo.sv
// Two-entry FIFO of weight/activation pairs; head is read directly from storage.
// Simultaneous push and pop are accepted even when full.
module pair_skid_fifo
    import fnn_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  pair_t      push_data,
    input  logic       pop,
    output pair_t      head,
    output logic [1:0] count,
    output logic       full,
    output logic       empty
);

    localparam int unsigned DEPTH = 2;

    pair_t      mem_q [DEPTH];
    logic       rd_q;
    logic       wr_q;
    logic [1:0] cnt_q;
    logic       do_push;
    logic       do_pop;

    assign empty   = (cnt_q == 2'd0);
    assign full    = (cnt_q == 2'(DEPTH));
    assign count   = cnt_q;
    assign head    = mem_q[rd_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointer/count update; the freed slot may be refilled in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= push_data;
                wr_q        <= ~wr_q;
            end
            if (do_pop) begin
                rd_q <= ~rd_q;
            end
            cnt_q <= cnt_q + 2'(do_push) - 2'(do_pop);
        end
    end

endmodule

// File: rtl/weight_fetch_sequencer.sv
// Walks one neuron's weight memory for a full pass, pairs each weight with its
// activation and streams the pairs to the MAC through a 2-entry skid FIFO.
module weight_fetch_sequencer
    import fnn_pkg::*;
#(
    parameter int unsigned numWeight    = FNN_NUM_W,
    parameter int unsigned dataWidth    = FNN_DATA_W,
    parameter int unsigned addressWidth = $clog2(numWeight)
) (
    input logic                      clk,
    input logic                      rst,
    weight_fetch_sequencer_if.master bus
);

    localparam int unsigned OCC_W = 3;
    localparam logic [addressWidth-1:0] LAST_IDX = addressWidth'(numWeight - 1);

    seq_state_t              state_q;
    seq_state_t              state_d;
    logic [addressWidth-1:0] idx_q;
    logic [addressWidth-1:0] radd_q;
    logic [dataWidth-1:0]    act_q;
    logic                    inflight_q;
    logic                    inflight_last_q;

    logic                    in_ready_c;
    logic                    issue_c;
    logic                    pop_c;
    logic                    push_c;
    logic [OCC_W-1:0]        occ_c;

    logic [1:0]              fifo_count;
    logic                    fifo_full;
    logic                    fifo_empty;
    pair_t                   push_pair;
    pair_t                   head_pair;

    // Occupancy counts the in-flight read as a reserved slot, net of this cycle's pop.
    assign pop_c  = !fifo_empty && bus.out_ready;
    assign occ_c  = OCC_W'(fifo_count) + OCC_W'(inflight_q) - OCC_W'(pop_c);
    assign push_c = inflight_q && (!fifo_full || pop_c);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        in_ready_c = 1'b0;
        issue_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                in_ready_c = !rst && (occ_c < OCC_W'(2));
                issue_c    = in_ready_c && bus.in_valid;
                if (issue_c && (idx_q == LAST_IDX)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (fifo_empty && !inflight_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Issue side: capture the activation alongside the read and mark the read in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q           <= '0;
            radd_q          <= '0;
            act_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            inflight_q <= issue_c;
            if ((state_q == IDLE) && bus.start) begin
                idx_q <= '0;
            end
            if (issue_c) begin
                radd_q          <= idx_q;
                act_q           <= bus.in_data;
                inflight_last_q <= (idx_q == LAST_IDX);
                if (idx_q != LAST_IDX) begin
                    idx_q <= idx_q + addressWidth'(1);
                end
            end
        end
    end

    always_comb begin
        push_pair        = '0;
        push_pair.weight = FNN_DATA_W'(bus.mem_wout);
        push_pair.data   = FNN_DATA_W'(act_q);
        push_pair.last   = inflight_last_q;
    end

    pair_skid_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_c),
        .push_data (push_pair),
        .pop       (pop_c),
        .head      (head_pair),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bus.busy       = seq_active(state_q);
    assign bus.done       = (state_q == DONE);
    assign bus.in_ready   = in_ready_c;
    assign bus.mem_ren    = issue_c;
    assign bus.mem_radd   = issue_c ? idx_q : radd_q;
    assign bus.out_valid  = !fifo_empty;
    assign bus.out_weight = dataWidth'(head_pair.weight);
    assign bus.out_data   = dataWidth'(head_pair.data);
    assign bus.out_last   = head_pair.last;

endmodule

// File: tb/tb_weight_fetch_sequencer.sv
// Directed bench for weight_fetch_sequencer with a registered-read memory model
// and a pair scoreboard filled on input handshakes and drained on MAC pops.
module tb_weight_fetch_sequencer;
    import fnn_pkg::*;

    localparam int unsigned NW = 30;
    localparam int unsigned DW = 16;
    localparam int unsigned AW = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    weight_fetch_sequencer_if #(.dataWidth(DW), .addressWidth(AW)) bus ();

    weight_fetch_sequencer #(.numWeight(NW), .dataWidth(DW), .addressWidth(AW)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic logic [DW-1:0] wval(input int i);
        return DW'(3 * i + 1);
    endfunction

    // Weight memory: one-cycle registered read.
    always @(posedge clk) begin
        if (bus.mem_ren) bus.mem_wout <= wval(int'(bus.mem_radd));
    end

    int    cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    pair_t q[$];
    pair_t want_p;
    pair_t got_p;
    int    issued = 0;
    int    pass_pairs = 0;
    int    done_cnt = 0;
    int    first_hs = -1;
    int    first_ov = -1;
    int    last_hs = 0;
    int    last_pop = 0;
    int    done_cyc = 0;
    bit    in_pass = 1'b0;
    bit    prev_done = 1'b0;
    bit    accept;

    // Monitor/scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            issued    = 0;
            in_pass   = 1'b0;
            prev_done = 1'b0;
        end else begin
            accept = bus.start && !bus.busy && !bus.done;
            if (accept) begin
                q.delete();
                issued     = 0;
                pass_pairs = 0;
                first_hs   = -1;
                first_ov   = -1;
            end
            if (in_pass && !bus.done) check("busy_in_pass", bus.busy, 1);
            if (bus.in_valid && bus.in_ready) begin
                check("mem_ren_on_hs", bus.mem_ren, 1);
                check("mem_radd", bus.mem_radd, issued);
                want_p.weight = wval(issued);
                want_p.data   = DW'(100 + issued);
                want_p.last   = (issued == NW - 1);
                q.push_back(want_p);
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
                issued++;
            end else begin
                check("mem_ren_idle", bus.mem_ren, 0);
            end
            if (bus.out_valid && first_ov < 0) first_ov = cyc;
            if (bus.out_valid && bus.out_ready) begin
                check("sb_nonempty_on_pop", (q.size() > 0), 1);
                if (q.size() > 0) begin
                    want_p       = q.pop_front();
                    got_p.weight = bus.out_weight;
                    got_p.data   = bus.out_data;
                    got_p.last   = bus.out_last;
                    check("pair_weight", got_p.weight, want_p.weight);
                    check("pair_data", got_p.data, want_p.data);
                    check("pair_last", got_p.last, want_p.last);
                end
                pass_pairs++;
                last_pop = cyc;
            end
            check("no_full_push", u_dut.inflight_q && u_dut.fifo_full && !u_dut.pop_c, 0);
            if (bus.done) begin
                check("done_width", prev_done, 0);
                done_cnt++;
                done_cyc = cyc;
                in_pass  = 1'b0;
            end
            prev_done = bus.done;
            if (accept) in_pass = 1'b1;
        end
    end

    bit pat_mode = 1'b0;
    bit rand_ready = 1'b0;
    int k = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        bus.in_data = DW'(100 + issued);
        if (pat_mode) begin
            bus.in_valid = ((k % 4) == 0) || ((k % 4) == 3);
            k++;
        end
        if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        check(tag, done_cnt - d0, 1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_in_ready"}, bus.in_ready, 0);
        check({tag, "_mem_ren"}, bus.mem_ren, 0);
        check({tag, "_mem_radd"}, bus.mem_radd, 0);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_out_last"}, bus.out_last, 0);
        check({tag, "_out_weight"}, bus.out_weight, 0);
        check({tag, "_out_data"}, bus.out_data, 0);
    endtask

    task automatic begin_pass();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int d0;
        int hit_run;
        int hit_drain;
        int hit_done;

        // Reset with random inputs, start included.
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            bus.start     = 1'($urandom);
            bus.in_valid  = 1'($urandom);
            bus.in_data   = DW'($urandom);
            bus.out_ready = 1'($urandom);
            #1;
            check_zero("reset");
        end
        @(posedge clk);
        #1;
        rst           = 1'b0;
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        check("start_in_rst_ignored", bus.busy, 0);
        check("no_done_after_rst", done_cnt, 0);

        // Full-rate pass.
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_data   = DW'(100);
        begin_pass();
        wait_done("passA_done", 200);
        check("passA_pairs", pass_pairs, NW);
        check("passA_latency", first_ov - first_hs, 2);
        check("passA_consecutive", last_hs - first_hs, NW - 1);
        check("passA_done_after_drain", done_cyc - last_pop, 2);
        check("passA_sb_empty", q.size(), 0);
        check("passA_idle_busy", bus.busy, 0);

        // Backpressure from the first cycle.
        bus.out_ready = 1'b0;
        begin_pass();
        repeat (4) tick();
        check("bp_handshakes", issued, 2);
        check("bp_in_ready", bus.in_ready, 0);
        repeat (10) begin
            tick();
            check("bp_hold_valid", bus.out_valid, 1);
            check("bp_hold_weight", bus.out_weight, wval(0));
            check("bp_hold_data", bus.out_data, 100);
        end
        check("bp_no_more_hs", issued, 2);
        bus.out_ready = 1'b1;
        wait_done("bp_done", 200);
        check("bp_pairs", pass_pairs, NW);
        check("bp_sb_empty", q.size(), 0);

        // Sparse input with random MAC stalls.
        k          = 0;
        pat_mode   = 1'b1;
        rand_ready = 1'b1;
        bus.in_valid = 1'b1;
        begin_pass();
        wait_done("rand_done", 800);
        pat_mode   = 1'b0;
        rand_ready = 1'b0;
        check("rand_pairs", pass_pairs, NW);
        check("rand_sb_empty", q.size(), 0);

        // Reset mid-pass near index 12, then a clean restart.
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        begin_pass();
        n = 0;
        #1;
        while (!(bus.mem_ren && bus.mem_radd == AW'(12)) && n < 100) begin
            tick();
            #1;
            n++;
        end
        check("midrst_reach_12", bus.mem_radd, 12);
        rst = 1'b1;
        tick();
        #1;
        check_zero("midrst");
        check("midrst_state", u_dut.state_q, IDLE);
        rst = 1'b0;
        repeat (3) tick();
        check("midrst_no_stale", bus.out_valid, 0);
        begin_pass();
        wait_done("restart_done", 200);
        check("restart_pairs", pass_pairs, NW);
        check("restart_sb_empty", q.size(), 0);

        // start pulses while RUN, DRAIN and DONE are all ignored.
        d0        = done_cnt;
        hit_run   = 0;
        hit_drain = 0;
        hit_done  = 0;
        begin_pass();
        for (int i = 0; i < 60; i++) begin
            tick();
            bus.start = 1'b0;
            if (u_dut.state_q == RUN && i == 5) begin
                bus.start = 1'b1;
                hit_run++;
            end
            if (u_dut.state_q == DRAIN) begin
                bus.start = 1'b1;
                hit_drain++;
            end
            if (u_dut.state_q == DONE) begin
                bus.start = 1'b1;
                hit_done++;
            end
        end
        bus.start = 1'b0;
        tick();
        check("ign_one_done", done_cnt - d0, 1);
        check("ign_pairs", pass_pairs, NW);
        check("ign_idle", bus.busy, 0);
        check("ign_hit_run", (hit_run > 0), 1);
        check("ign_hit_drain", (hit_drain > 0), 1);
        check("ign_hit_done", (hit_done > 0), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
